// File: rtl/mem_pkg.sv
// Shared widths, bus layouts, size encodings and FSM states for the memory-access stage.
package mem_pkg;

  localparam int RegAddrBusW    = 5;
  localparam int MemCtlW        = 5;
  localparam int EXE2MEMBusSize = 107;
  localparam int MEM2WBBusSize  = 102;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } mem_state_e;

  // mem_ctl: [4] load, [3] store, [2] unsigned, [1:0] size
  typedef struct packed {
    logic [MemCtlW-1:0]     mem_ctl;
    logic [31:0]            st_data;
    logic [31:0]            alu_result;
    logic [RegAddrBusW-1:0] wdest;
    logic                   we;
    logic [31:0]            pc;
  } exe2mem_bus_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store strobes/replicated data and load extract with sign/zero extension.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic signed [7:0]  ld_b;
  logic signed [15:0] ld_h;

  always_comb begin
    wstrb_o   = 4'b1111;
    wdata_o   = st_data_i;
    ld_data_o = rdata_i;
    ld_b      = rdata_i[{addr_lo_i, 3'b000} +: 8];
    ld_h      = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SIZE_BYTE: begin
        wstrb_o   = 4'b0001 << addr_lo_i;
        wdata_o   = {4{st_data_i[7:0]}};
        ld_data_o = uns_i ? {24'b0, ld_b} : 32'(ld_b);
      end
      // Misaligned halves drop addr[0] and land on the enclosing half-word.
      SIZE_HALF: begin
        wstrb_o   = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o   = {2{st_data_i[15:0]}};
        ld_data_o = uns_i ? {16'b0, ld_h} : 32'(ld_h);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem.sv
// Memory-access pipeline stage: issues data-memory requests and drives the registered MEM->WB bus.
module mem
  import mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [EXE2MEMBusSize-1:0] exe2mem_bus_ri,
  input  logic                      ctl_mem_valid_i,
  output logic                      ctl_mem_over_o,
  output logic                      ctl_mem_allowin_o,
  output logic [RegAddrBusW-1:0]    ctl_mem_dest_o,
  input  logic                      ctl_wb_allowin_i,
  output logic [MEM2WBBusSize-1:0]  mem2wb_bus_o,
  output logic                      ctl_wb_valid_o,
  output logic                      dm_req_o,
  output logic                      dm_we_o,
  output logic [31:0]               dm_addr_o,
  output logic [3:0]                dm_wstrb_o,
  output logic [31:0]               dm_wdata_o,
  input  logic                      dm_ready_i,
  input  logic                      dm_rvalid_i,
  input  logic [31:0]               dm_rdata_i
);

  exe2mem_bus_t             bus;
  logic                     is_load, is_store, is_mem;
  logic [31:0]              ld_ext, result, dbg_addr;
  mem_state_e               state_q, state_d;
  logic [31:0]              hold_q, hold_d;
  logic [MEM2WBBusSize-1:0] wb_bus_q, wb_bus_d;
  logic                     wb_valid_q;
  logic                     over, req;

  assign bus      = exe2mem_bus_ri;
  assign is_load  = bus.mem_ctl[4];
  assign is_store = bus.mem_ctl[3];
  assign is_mem   = is_load | is_store;

  mem_align u_align (
    .size_i    (bus.mem_ctl[1:0]),
    .uns_i     (bus.mem_ctl[2]),
    .addr_lo_i (bus.alu_result[1:0]),
    .st_data_i (bus.st_data),
    .rdata_i   (dm_rdata_i),
    .wstrb_o   (dm_wstrb_o),
    .wdata_o   (dm_wdata_o),
    .ld_data_o (ld_ext)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    over    = 1'b0;
    req     = 1'b0;
    if (ctl_mem_valid_i) begin
      case (state_q)
        S_IDLE, S_REQ: begin
          if (state_q == S_IDLE && !is_mem) begin
            over = ctl_wb_allowin_i;
          end else begin
            req = 1'b1;
            if (dm_ready_i) begin
              if (is_store) begin
                over    = ctl_wb_allowin_i;
                state_d = ctl_wb_allowin_i ? S_IDLE : S_HOLD;
              end else begin
                state_d = S_WAIT;
              end
            end else begin
              state_d = S_REQ;
            end
          end
        end
        S_WAIT: begin
          if (dm_rvalid_i) begin
            if (ctl_wb_allowin_i) begin
              over    = 1'b1;
              state_d = S_IDLE;
            end else begin
              hold_d  = ld_ext;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          over = ctl_wb_allowin_i;
          if (ctl_wb_allowin_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Reset must win over a same-cycle handshake so memory never sees an acceptance.
    if (rst) begin
      over = 1'b0;
      req  = 1'b0;
    end
  end

  assign result   = is_load ? ((state_q == S_HOLD) ? hold_q : ld_ext) : bus.alu_result;
  assign dbg_addr = is_mem ? dm_addr_o : 32'h0;
  assign wb_bus_d = {bus.wdest, bus.we, result, dbg_addr, bus.pc};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_q     <= 32'h0;
      wb_valid_q <= 1'b0;
      wb_bus_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (ctl_wb_allowin_i) wb_valid_q <= over;
      if (over) wb_bus_q <= wb_bus_d;
    end
  end

  assign dm_req_o          = req;
  assign dm_we_o           = req & is_store;
  assign dm_addr_o         = {bus.alu_result[31:2], 2'b00};
  assign ctl_mem_over_o    = over;
  assign ctl_mem_allowin_o = !ctl_mem_valid_i | over;
  assign ctl_mem_dest_o    = (ctl_mem_valid_i && bus.we) ? bus.wdest : '0;
  assign mem2wb_bus_o      = wb_bus_q;
  assign ctl_wb_valid_o    = wb_valid_q;

endmodule

// File: tb/tb_mem.sv
// Table-driven bench for the memory-access stage with a WB-side scoreboard.
module tb_mem;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic [EXE2MEMBusSize-1:0] bus;
  logic                      valid, wb_allowin;
  logic                      over, allowin, wb_valid;
  logic [RegAddrBusW-1:0]    dest;
  logic [MEM2WBBusSize-1:0]  wb_bus;
  logic                      req, we;
  logic [31:0]               addr, wdata, rdata;
  logic [3:0]                wstrb;
  logic                      ready, rvalid;

  mem dut (
    .clk               (clk),
    .rst               (rst),
    .exe2mem_bus_ri    (bus),
    .ctl_mem_valid_i   (valid),
    .ctl_mem_over_o    (over),
    .ctl_mem_allowin_o (allowin),
    .ctl_mem_dest_o    (dest),
    .ctl_wb_allowin_i  (wb_allowin),
    .mem2wb_bus_o      (wb_bus),
    .ctl_wb_valid_o    (wb_valid),
    .dm_req_o          (req),
    .dm_we_o           (we),
    .dm_addr_o         (addr),
    .dm_wstrb_o        (wstrb),
    .dm_wdata_o        (wdata),
    .dm_ready_i        (ready),
    .dm_rvalid_i       (rvalid),
    .dm_rdata_i        (rdata)
  );

  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] st;
    logic [31:0] alu;
    logic [4:0]  wd;
    logic        wen;
    logic [31:0] pc;
    int          rdy_dly;
    int          rv_dly;
    logic [31:0] rd;
    logic [31:0] exp_res;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [MEM2WBBusSize-1:0] sb_q[$];
  vec_t vecs[15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EXE2MEMBusSize-1:0] mk_in(input vec_t v);
    return {v.ctl, v.st, v.alu, v.wd, v.wen, v.pc};
  endfunction

  function automatic logic [MEM2WBBusSize-1:0] mk_out(input vec_t v);
    logic m;
    m = v.ctl[4] | v.ctl[3];
    return {v.wd, v.wen, v.exp_res, (m ? v.exp_addr : 32'h0), v.pc};
  endfunction

  always @(negedge clk) begin : wb_mon
    logic [MEM2WBBusSize-1:0] e;
    if (!rst && wb_valid && wb_allowin) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", wb_valid, 1'b0);
      end else begin
        e = sb_q.pop_front();
        chk("wb_bus", wb_bus, e);
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    logic ld, st;
    ld = v.ctl[4];
    st = v.ctl[3];
    @(posedge clk); #1;
    bus = mk_in(v); valid = 1'b1; ready = 1'b0; rvalid = 1'b0;
    sb_q.push_back(mk_out(v));
    if (ld || st) begin
      for (int i = 0; i < v.rdy_dly; i++) begin
        @(negedge clk);
        chk($sformatf("v%0d_req_wait", idx), {req, over, allowin}, 3'b100);
        chk($sformatf("v%0d_req_addr", idx), addr, v.exp_addr);
        if (st) chk($sformatf("v%0d_req_lanes", idx), {wstrb, wdata}, {v.exp_strb, v.exp_wdata});
        @(posedge clk); #1;
      end
      ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_dest", idx), dest, v.wen ? v.wd : 5'd0);
      chk($sformatf("v%0d_acc_req_we", idx), {req, we}, {1'b1, st});
      chk($sformatf("v%0d_acc_addr", idx), addr, v.exp_addr);
      if (st) begin
        chk($sformatf("v%0d_acc_lanes", idx), {wstrb, wdata}, {v.exp_strb, v.exp_wdata});
        chk($sformatf("v%0d_st_over", idx), {over, allowin}, 2'b11);
      end else begin
        chk($sformatf("v%0d_ld_no_over", idx), over, 1'b0);
      end
      @(posedge clk); #1;
      ready = 1'b0;
      if (ld) begin
        for (int i = 1; i < v.rv_dly; i++) begin
          @(negedge clk);
          chk($sformatf("v%0d_wait", idx), {req, over}, 2'b00);
          @(posedge clk); #1;
        end
        rvalid = 1'b1; rdata = v.rd;
        @(negedge clk);
        chk($sformatf("v%0d_rv_over", idx), {over, allowin}, 2'b11);
        @(posedge clk); #1;
        rvalid = 1'b0; rdata = 32'h0;
      end
    end else begin
      @(negedge clk);
      chk($sformatf("v%0d_dest", idx), dest, v.wen ? v.wd : 5'd0);
      chk($sformatf("v%0d_alu_over", idx), {req, over}, 2'b01);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_wb_valid", idx), wb_valid, 1'b1);
  endtask

  initial begin
    vecs[0]  = '{5'b00000, 32'h0, 32'h1234, 5'd3, 1'b1, 32'h1000, 0, 0, 32'h0, 32'h1234, 32'h0, 4'h0, 32'h0};
    vecs[1]  = '{5'b10000, 32'h0, 32'h103, 5'd5, 1'b1, 32'h1004, 0, 1, 32'h80FFFFFF, 32'hFFFFFF80, 32'h100, 4'h0, 32'h0};
    vecs[2]  = '{5'b10100, 32'h0, 32'h103, 5'd6, 1'b1, 32'h1008, 1, 2, 32'h80FFFFFF, 32'h00000080, 32'h100, 4'h0, 32'h0};
    vecs[3]  = '{5'b01001, 32'h0000ABCD, 32'h202, 5'd0, 1'b0, 32'h100C, 0, 0, 32'h0, 32'h202, 32'h200, 4'b1100, 32'hABCDABCD};
    vecs[4]  = '{5'b10001, 32'h0, 32'h302, 5'd7, 1'b1, 32'h1010, 0, 1, 32'h80011234, 32'hFFFF8001, 32'h300, 4'h0, 32'h0};
    vecs[5]  = '{5'b10101, 32'h0, 32'h300, 5'd8, 1'b1, 32'h1014, 0, 1, 32'h1234F00D, 32'h0000F00D, 32'h300, 4'h0, 32'h0};
    vecs[6]  = '{5'b10010, 32'h0, 32'h404, 5'd9, 1'b1, 32'h1018, 2, 3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h404, 4'h0, 32'h0};
    vecs[7]  = '{5'b01000, 32'h12345677, 32'h501, 5'd0, 1'b0, 32'h101C, 1, 0, 32'h0, 32'h501, 32'h500, 4'b0010, 32'h77777777};
    vecs[8]  = '{5'b01010, 32'hCAFEBABE, 32'h603, 5'd0, 1'b0, 32'h1020, 0, 0, 32'h0, 32'h603, 32'h600, 4'b1111, 32'hCAFEBABE};
    vecs[9]  = '{5'b01001, 32'hFFFF5A5A, 32'h201, 5'd0, 1'b0, 32'h1024, 0, 0, 32'h0, 32'h201, 32'h200, 4'b0011, 32'h5A5A5A5A};
    vecs[10] = '{5'b10010, 32'h0, 32'h702, 5'd10, 1'b1, 32'h1028, 0, 1, 32'h01020304, 32'h01020304, 32'h700, 4'h0, 32'h0};
    vecs[11] = '{5'b10000, 32'h0, 32'h101, 5'd11, 1'b1, 32'h102C, 0, 2, 32'h00007F00, 32'h0000007F, 32'h100, 4'h0, 32'h0};
    vecs[12] = '{5'b00000, 32'hFFFF, 32'h89ABCDEF, 5'd7, 1'b0, 32'h1030, 0, 0, 32'h0, 32'h89ABCDEF, 32'h0, 4'h0, 32'h0};
    vecs[13] = '{5'b01100, 32'h000000C3, 32'h7FF, 5'd0, 1'b0, 32'h1034, 0, 0, 32'h0, 32'h7FF, 32'h7FC, 4'b1000, 32'hC3C3C3C3};
    vecs[14] = '{5'b10101, 32'h0, 32'h802, 5'd12, 1'b1, 32'h1038, 1, 1, 32'hBEEF0000, 32'h0000BEEF, 32'h800, 4'h0, 32'h0};

    // Reset, with a load sitting on the bus but not valid.
    rst = 1'b1; valid = 1'b0; wb_allowin = 1'b1; ready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    bus = mk_in(vecs[1]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {req, over}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_bus", wb_bus, '0);
    chk("idle_ctl", {req, over, allowin}, 3'b001);
    chk("idle_dest", dest, 5'd0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Load data arrives while WB stalls for two cycles; hold register must keep it.
    @(posedge clk); #1;
    bus = mk_in('{5'b10001, 32'h0, 32'h802, 5'd13, 1'b1, 32'h2000, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0});
    sb_q.push_back({5'd13, 1'b1, 32'hFFFF9ABC, 32'h800, 32'h2000});
    valid = 1'b1; ready = 1'b1;
    @(negedge clk); chk("hl_req", req, 1'b1);
    @(posedge clk); #1;
    ready = 1'b0; rvalid = 1'b1; rdata = 32'h9ABC0000; wb_allowin = 1'b0;
    @(negedge clk); chk("hl_rv_stall", {over, allowin}, 2'b00);
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = 32'h11112222;
    @(negedge clk); chk("hl_hold", {req, over}, 2'b00);
    @(posedge clk); #1;
    wb_allowin = 1'b1;
    @(negedge clk); chk("hl_over", over, 1'b1);
    @(posedge clk); #1;
    valid = 1'b0; rdata = 32'h0;
    @(negedge clk); chk("hl_wb_valid", wb_valid, 1'b1);

    // Store accepted while WB stalls: no second request from HOLD.
    @(posedge clk); #1;
    bus = mk_in('{5'b01010, 32'h13579BDF, 32'h900, 5'd0, 1'b0, 32'h2004, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0});
    sb_q.push_back({5'd0, 1'b0, 32'h900, 32'h900, 32'h2004});
    valid = 1'b1; ready = 1'b1; wb_allowin = 1'b0;
    @(negedge clk); chk("sh_acc", {req, we, over}, 3'b110);
    @(posedge clk); #1;
    ready = 1'b0;
    @(negedge clk); chk("sh_hold", {req, over}, 2'b00);
    @(posedge clk); #1;
    wb_allowin = 1'b1;
    @(negedge clk); chk("sh_over", {req, over}, 2'b01);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk); chk("sh_wb_valid", wb_valid, 1'b1);

    // Reset while waiting for load data; late rvalid must be dropped.
    @(posedge clk); #1;
    bus = mk_in('{5'b10010, 32'h0, 32'hA00, 5'd14, 1'b1, 32'h2008, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0});
    valid = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); chk("rw_rst", {req, over}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;
    @(negedge clk); chk("rw_wb_valid", wb_valid, 1'b0);
    @(posedge clk); #1;
    rvalid = 1'b1; rdata = 32'h55AA55AA;
    @(negedge clk); chk("rw_late_rv", {req, over}, 2'b00);
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = 32'h0;
    @(negedge clk); chk("rw_no_wb", wb_valid, 1'b0);

    // Reset and ready together in REQ: reset wins.
    @(posedge clk); #1;
    bus = mk_in('{5'b01000, 32'h000000EE, 32'hB03, 5'd0, 1'b0, 32'h200C, 0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0});
    valid = 1'b1; ready = 1'b0;
    @(negedge clk); chk("rr_req", req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; ready = 1'b1;
    @(negedge clk); chk("rr_rst_wins", {req, over}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; ready = 1'b0; valid = 1'b0;
    @(negedge clk); chk("rr_no_wb", {wb_valid, req}, 2'b00);

    // Pipeline works normally after the abandoned ops.
    run_vec(vecs[6], 100);
    run_vec(vecs[0], 101);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
